// File: rtl/dma_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | dma_pkg : engine state encoding and memory-port width codes      |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    LAT  = 2'd2,
    WR   = 2'd3
  } dma_state_t;

  // Width codes understood by the memory controller data port
  localparam logic [1:0] WIDTH_WORD = 2'd0;
  localparam logic [1:0] WIDTH_BYTE = 2'd1;
  localparam logic [1:0] WIDTH_HALF = 2'd2;

endpackage
`default_nettype wire

// File: rtl/dma_engine.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | dma_engine : word-copy DMA sharing the memory data port with CPU |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
module dma_engine
  import dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [31:0]      i_src,
  input  logic [31:0]      i_dst,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic [LEN_W-1:0] o_count,
  input  logic             i_grant,
  output logic [31:0]      o_addr,
  output logic [31:0]      o_wdata,
  output logic [1:0]       o_width,
  output logic             o_we,
  output logic             o_read_en,
  output logic             o_zeroextend,
  input  logic [31:0]      i_rdata
);

  dma_state_t       r_state;
  dma_state_t       w_next;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [31:0]      r_buf;
  logic [LEN_W-1:0] r_remaining;
  logic [LEN_W-1:0] r_count;
  logic             r_zero_done;
  logic             w_rd_issue;
  logic             w_wr_issue;
  logic             w_last;
  logic             w_start_ok;
  logic             w_unused_align;

  // Byte-offset bits of the addresses are deliberately dropped
  assign w_unused_align = ^{i_src[1:0], i_dst[1:0]};
  assign w_start_ok     = (r_state == IDLE) && i_start && (i_len != '0);

  always_comb begin
    w_next     = r_state;
    w_rd_issue = 1'b0;
    w_wr_issue = 1'b0;
    w_last     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_ok) w_next = RD;
      end
      RD: begin
        if (i_abort) begin
          w_next = IDLE;
        end else if (i_grant) begin
          w_rd_issue = 1'b1;
          w_next     = LAT;
        end
      end
      LAT: begin
        w_next = i_abort ? IDLE : WR;
      end
      WR: begin
        if (i_abort) begin
          w_next = IDLE;
        end else if (i_grant) begin
          w_wr_issue = 1'b1;
          w_last     = !(r_remaining > LEN_W'(1));
          w_next     = w_last ? IDLE : RD;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_buf       <= '0;
      r_remaining <= '0;
      r_count     <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_zero_done <= (r_state == IDLE) && i_start && (i_len == '0);
      if ((r_state == IDLE) && i_start) begin
        r_count <= '0;
        if (i_len != '0) begin
          r_src       <= {i_src[31:2], 2'b00};
          r_dst       <= {i_dst[31:2], 2'b00};
          r_remaining <= i_len;
        end
      end
      // Read data arrives one cycle after issue, i.e. while in LAT
      if (r_state == LAT) r_buf <= i_rdata;
      if (w_wr_issue) begin
        r_src       <= r_src + 32'd4;
        r_dst       <= r_dst + 32'd4;
        r_count     <= r_count + LEN_W'(1);
        r_remaining <= r_remaining - LEN_W'(1);
      end
    end
  end

  always_comb begin
    o_addr    = '0;
    o_wdata   = '0;
    o_we      = 1'b0;
    o_read_en = 1'b0;
    if (w_rd_issue) begin
      o_read_en = 1'b1;
      o_addr    = r_src;
    end else if (w_wr_issue) begin
      o_we    = 1'b1;
      o_addr  = r_dst;
      o_wdata = r_buf;
    end
  end

  assign o_done       = (w_wr_issue && w_last) || r_zero_done;
  assign o_busy       = (r_state != IDLE);
  assign o_count      = r_count;
  assign o_width      = WIDTH_WORD;
  assign o_zeroextend = 1'b0;

endmodule
`default_nettype wire
